layer_output_serializer: RTL and testbench

- Takes the parallel result vector of one fully-connected layer (NN neuron outputs plus per-neuron valid bits) and replays it as a serial stream, one element per clock.
- The serial stream (o_data / o_valid) drives the next layer's x_in / x_valid, so layers can be chained without a host in the loop.
- Holds one captured vector, plus a second pending vector when double buffering is compiled in. Flags protocol violations with sticky error bits.

---
 rtl/layer_output_serializer.sv | 137 +++++++++++++
 tb/tb_layer_output_serializer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/layer_output_serializer.sv
// Replays one layer's parallel result vector as a serial element stream for the next layer.
// Optional SERIALIZER_DOUBLE_BUFFER_EN adds a pending-vector buffer so a capture during a stream is kept.
module layer_output_serializer #(
    parameter int unsigned NN        = 30,
    parameter int unsigned dataWidth = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NN-1:0]           i_valid,
    input  logic [NN*dataWidth-1:0] i_data,
    output logic                    o_valid,
    output logic [dataWidth-1:0]    o_data,
    output logic                    o_last,
    output logic                    o_busy,
    output logic                    o_overrun,
    output logic                    o_partial_err
);
    localparam int unsigned IW = (NN > 1) ? $clog2(NN) : 1;
    localparam int unsigned VW = NN * dataWidth;
    localparam logic [IW-1:0] LAST_IDX = IW'(NN - 1);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [IW-1:0] idx_inc;
    logic [VW-1:0] act_buf;
    logic          pend_full;
    logic          capture;
    logic          partial;
    logic          drop;
    logic          start;
    logic [VW-1:0] start_vec;

    function automatic logic [dataWidth-1:0] elem(input logic [VW-1:0] v, input int unsigned k);
        return v[k*dataWidth +: dataWidth];
    endfunction

    assign capture = &i_valid;
    assign partial = (|i_valid) && !capture;
    assign idx_inc = idx + IW'(1);

`ifdef SERIALIZER_DOUBLE_BUFFER_EN
    logic [VW-1:0] pend_buf;

    // Pending slot: filled mid-stream, drained (or refilled) on the last element.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_buf  <= '0;
            pend_full <= 1'b0;
        end else if (state == SHIFT) begin
            if (!o_last) begin
                if (capture && !pend_full) begin
                    pend_buf  <= i_data;
                    pend_full <= 1'b1;
                end
            end else if (pend_full) begin
                if (capture) begin
                    pend_buf <= i_data;
                end else begin
                    pend_full <= 1'b0;
                end
            end
        end
    end

    assign drop = capture && (state == SHIFT) && !o_last && pend_full;

    always_comb begin
        start     = 1'b0;
        start_vec = i_data;
        if (state == IDLE) begin
            start = capture;
        end else if (o_last) begin
            if (pend_full) begin
                start     = 1'b1;
                start_vec = pend_buf;
            end else begin
                start = capture;
            end
        end
    end
`else
    assign pend_full = 1'b0;
    assign drop      = capture && (state == SHIFT) && !o_last;

    always_comb begin
        start     = 1'b0;
        start_vec = i_data;
        if (state == IDLE || o_last) begin
            start = capture;
        end
    end
`endif

    // Stream FSM: a start loads element 0 straight into the output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            idx           <= '0;
            act_buf       <= '0;
            o_valid       <= 1'b0;
            o_data        <= '0;
            o_last        <= 1'b0;
            o_overrun     <= 1'b0;
            o_partial_err <= 1'b0;
        end else begin
            if (partial) begin
                o_partial_err <= 1'b1;
            end
            if (drop) begin
                o_overrun <= 1'b1;
            end
            if (start) begin
                state   <= SHIFT;
                idx     <= '0;
                act_buf <= start_vec;
                o_valid <= 1'b1;
                o_data  <= start_vec[dataWidth-1:0];
                o_last  <= (NN == 1);
            end else if (state == SHIFT && !o_last) begin
                idx    <= idx_inc;
                o_data <= elem(act_buf, int'(idx_inc));
                o_last <= (idx_inc == LAST_IDX);
            end else begin
                state   <= IDLE;
                idx     <= '0;
                o_valid <= 1'b0;
                o_data  <= '0;
                o_last  <= 1'b0;
            end
        end
    end

    assign o_busy = (state == SHIFT) || pend_full;

endmodule

// File: tb/tb_layer_output_serializer.sv
// Directed bench for layer_output_serializer: NN=4 and NN=1 instances, table vectors plus corner sequences.
module tb_layer_output_serializer;
    localparam int unsigned DW = 16;
    localparam logic [63:0] D1 = 64'h0004_0003_0002_0001;
    localparam logic [63:0] D2 = 64'h0008_0007_0006_0005;
    localparam logic [63:0] D3 = 64'h00DD_00CC_00BB_00AA;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    i_valid = '0;
    logic [63:0]   i_data = '0;
    logic          o_valid, o_last, o_busy, o_overrun, o_partial_err;
    logic [DW-1:0] o_data;
    logic [0:0]    i_valid1 = '0;
    logic [15:0]   i_data1 = '0;
    logic          o_valid1, o_last1, o_busy1, o_overrun1, o_partial_err1;
    logic [DW-1:0] o_data1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    layer_output_serializer #(.NN(4), .dataWidth(DW)) u_dut4 (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data),
        .o_valid(o_valid), .o_data(o_data), .o_last(o_last), .o_busy(o_busy),
        .o_overrun(o_overrun), .o_partial_err(o_partial_err)
    );

    layer_output_serializer #(.NN(1), .dataWidth(DW)) u_dut1 (
        .clk(clk), .rst(rst), .i_valid(i_valid1), .i_data(i_data1),
        .o_valid(o_valid1), .o_data(o_data1), .o_last(o_last1), .o_busy(o_busy1),
        .o_overrun(o_overrun1), .o_partial_err(o_partial_err1)
    );

    typedef struct {
        logic [3:0]  v;
        logic [63:0] d;
        logic        ev;
        logic [15:0] ed;
        logic        el;
        logic        eb;
        logic        ep;
    } vec_t;

    vec_t tbl [21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock with the given inputs, outputs checked 1 time unit after the edge.
    task automatic step(input vec_t s, input logic eovr, input string tag);
        i_valid = s.v;
        i_data  = s.d;
        @(posedge clk);
        #1;
        i_valid = '0;
        chk({tag, ".valid"}, 32'(o_valid), 32'(s.ev));
        if (s.ev) chk({tag, ".data"}, 32'(o_data), 32'(s.ed));
        chk({tag, ".last"}, 32'(o_last), 32'(s.el));
        chk({tag, ".busy"}, 32'(o_busy), 32'(s.eb));
        chk({tag, ".overrun"}, 32'(o_overrun), 32'(eovr));
        chk({tag, ".partial"}, 32'(o_partial_err), 32'(s.ep));
    endtask

    task automatic step1(input logic v, input logic [15:0] d, input logic ev,
                         input logic [15:0] ed, input string tag);
        i_valid1 = v;
        i_data1  = d;
        @(posedge clk);
        #1;
        i_valid1 = '0;
        chk({tag, ".valid"}, 32'(o_valid1), 32'(ev));
        if (ev) chk({tag, ".data"}, 32'(o_data1), 32'(ed));
        chk({tag, ".last"}, 32'(o_last1), 32'(ev));
        chk({tag, ".busy"}, 32'(o_busy1), 32'(ev));
        chk({tag, ".overrun"}, 32'(o_overrun1), 32'(0));
    endtask

    initial begin
        vec_t s;
        // Single vector, back-to-back on o_last, then partial valid and a normal vector after it.
        tbl[0]  = '{4'hF, D1, 1, 16'd1, 0, 1, 0};
        tbl[1]  = '{4'h0, 0,  1, 16'd2, 0, 1, 0};
        tbl[2]  = '{4'h0, 0,  1, 16'd3, 0, 1, 0};
        tbl[3]  = '{4'h0, 0,  1, 16'd4, 1, 1, 0};
        tbl[4]  = '{4'h0, 0,  0, 16'd0, 0, 0, 0};
        tbl[5]  = '{4'hF, D1, 1, 16'd1, 0, 1, 0};
        tbl[6]  = '{4'h0, 0,  1, 16'd2, 0, 1, 0};
        tbl[7]  = '{4'h0, 0,  1, 16'd3, 0, 1, 0};
        tbl[8]  = '{4'h0, 0,  1, 16'd4, 1, 1, 0};
        tbl[9]  = '{4'hF, D2, 1, 16'd5, 0, 1, 0};
        tbl[10] = '{4'h0, 0,  1, 16'd6, 0, 1, 0};
        tbl[11] = '{4'h0, 0,  1, 16'd7, 0, 1, 0};
        tbl[12] = '{4'h0, 0,  1, 16'd8, 1, 1, 0};
        tbl[13] = '{4'h0, 0,  0, 16'd0, 0, 0, 0};
        tbl[14] = '{4'h5, D2, 0, 16'd0, 0, 0, 1};
        tbl[15] = '{4'h0, 0,  0, 16'd0, 0, 0, 1};
        tbl[16] = '{4'hF, D2, 1, 16'd5, 0, 1, 1};
        tbl[17] = '{4'h0, 0,  1, 16'd6, 0, 1, 1};
        tbl[18] = '{4'h0, 0,  1, 16'd7, 0, 1, 1};
        tbl[19] = '{4'h0, 0,  1, 16'd8, 1, 1, 1};
        tbl[20] = '{4'h0, 0,  0, 16'd0, 0, 0, 1};

        repeat (2) @(posedge clk);
        #1;
        chk("rst.valid", 32'(o_valid), 0);
        chk("rst.data", 32'(o_data), 0);
        chk("rst.last", 32'(o_last), 0);
        chk("rst.busy", 32'(o_busy), 0);
        chk("rst.overrun", 32'(o_overrun), 0);
        chk("rst.partial", 32'(o_partial_err), 0);
        @(negedge clk);
        rst = 1'b0;

        // NN=1: single element stream, then two consecutive captures.
        step1(1'b1, 16'hABCD, 1, 16'hABCD, "nn1.a");
        step1(1'b0, 16'h0000, 0, 16'h0000, "nn1.b");
        step1(1'b1, 16'h1111, 1, 16'h1111, "nn1.c");
        step1(1'b1, 16'h2222, 1, 16'h2222, "nn1.d");
        step1(1'b0, 16'h0000, 0, 16'h0000, "nn1.e");

        for (int i = 0; i < 21; i++) begin
            step(tbl[i], 1'b0, $sformatf("tbl%0d", i));
        end

        // Second capture on the 2nd output cycle.
        step('{4'hF, D1, 1, 16'd1, 0, 1, 1}, 1'b0, "ovr.a");
        step('{4'h0, 0,  1, 16'd2, 0, 1, 1}, 1'b0, "ovr.b");
`ifdef SERIALIZER_DOUBLE_BUFFER_EN
        step('{4'hF, D2, 1, 16'd3, 0, 1, 1}, 1'b0, "ovr.c");
        step('{4'h0, 0,  1, 16'd4, 1, 1, 1}, 1'b0, "ovr.d");
        step('{4'h0, 0,  1, 16'd5, 0, 1, 1}, 1'b0, "ovr.e");
        step('{4'h0, 0,  1, 16'd6, 0, 1, 1}, 1'b0, "ovr.f");
        step('{4'h0, 0,  1, 16'd7, 0, 1, 1}, 1'b0, "ovr.g");
        step('{4'h0, 0,  1, 16'd8, 1, 1, 1}, 1'b0, "ovr.h");
        step('{4'h0, 0,  0, 16'd0, 0, 0, 1}, 1'b0, "ovr.i");
`else
        step('{4'hF, D2, 1, 16'd3, 0, 1, 1}, 1'b1, "ovr.c");
        step('{4'h0, 0,  1, 16'd4, 1, 1, 1}, 1'b1, "ovr.d");
        step('{4'h0, 0,  0, 16'd0, 0, 0, 1}, 1'b1, "ovr.e");
        step('{4'h0, 0,  0, 16'd0, 0, 0, 1}, 1'b1, "ovr.f");
`endif

        // Asynchronous reset in the middle of element 2.
        step('{4'hF, D1, 1, 16'd1, 0, 1, 1}, o_overrun, "ar.a");
        step('{4'h0, 0,  1, 16'd2, 0, 1, 1}, o_overrun, "ar.b");
        s = '{4'h0, 0, 1, 16'd3, 0, 1, 1};
        step(s, o_overrun, "ar.c");
        #2;
        rst = 1'b1;
        #1;
        chk("ar.rst.valid", 32'(o_valid), 0);
        chk("ar.rst.last", 32'(o_last), 0);
        chk("ar.rst.busy", 32'(o_busy), 0);
        chk("ar.rst.overrun", 32'(o_overrun), 0);
        chk("ar.rst.partial", 32'(o_partial_err), 0);
        @(negedge clk);
        rst = 1'b0;
        step('{4'h0, 0,  0, 16'd0,    0, 0, 0}, 1'b0, "ar.d");
        step('{4'hF, D3, 1, 16'h00AA, 0, 1, 0}, 1'b0, "ar.e");
        step('{4'h0, 0,  1, 16'h00BB, 0, 1, 0}, 1'b0, "ar.f");
        step('{4'h0, 0,  1, 16'h00CC, 0, 1, 0}, 1'b0, "ar.g");
        step('{4'h0, 0,  1, 16'h00DD, 1, 1, 0}, 1'b0, "ar.h");
        step('{4'h0, 0,  0, 16'd0,    0, 0, 0}, 1'b0, "ar.i");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
